// File: rtl/decod_pkg.sv
// Shared types for the opcode sequencer: FSM state encoding and opcode names.
package decod_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_SOMA  = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_MULTI = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_AND   = 3'd4;
   localparam logic [2:0] OP_OR    = 3'd5;
   localparam logic [2:0] OP_XOR   = 3'd6;
   localparam logic [2:0] OP_NOT   = 3'd7;

   // True when opcode value v names a legal operation for a decoder of n ops.
   function automatic logic op_legal(input int unsigned v, input int unsigned n);
      return (v < n);
   endfunction

endpackage

// File: rtl/decodificador_op_seq_if.sv
// Opcode request / decode-result bundle between an issuer (master) and the sequencer (slave).
// Request side is valid/ready; result side is a set of registered status outputs.
interface decodificador_op_seq_if #(
   parameter int OP_W    = 3,
   parameter int NUM_OPS = 8
);
   logic                op_valid;
   logic [OP_W-1:0]     op;
   logic                op_ready;
   logic [NUM_OPS-1:0]  sel;
   logic [OP_W-1:0]     op_q;
   logic                busy;
   logic                done;
   logic                illegal;

   modport master (
      output op_valid, op,
      input  op_ready, sel, op_q, busy, done, illegal
   );

   modport slave (
      input  op_valid, op,
      output op_ready, sel, op_q, busy, done, illegal
   );
endinterface

// File: rtl/decod_onehot.sv
// Combinational opcode-to-one-hot decoder, zero output for opcodes >= NUM_OPS.
// Latency 0; no flow control.
module decod_onehot #(
   parameter int OP_W    = 3,
   parameter int NUM_OPS = 8
) (
   input  logic [OP_W-1:0]    i_op,
   output logic [NUM_OPS-1:0] o_sel
);

   always_comb begin
      o_sel = '0;
      for (int i = 0; i < NUM_OPS; i++) begin
         if (i_op == OP_W'(i)) begin
            o_sel[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decodificador_op_seq.sv
// Opcode sequencer: IDLE/EXEC/DONE, done 1 cycle after accept (MC_LAT+1 for multi-cycle ops).
// op_ready low only in EXEC; optional abort port with `define DECOD_ABORT_EN.
module decodificador_op_seq
   import decod_pkg::*;
#(
   parameter int                 OP_W    = 3,
   parameter int                 NUM_OPS = 8,
   parameter logic [NUM_OPS-1:0] MC_MASK = NUM_OPS'(12),
   parameter int                 MC_LAT  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef DECOD_ABORT_EN
   input  logic                  abort,
`endif
   decodificador_op_seq_if.slave bus
);

   localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
   localparam int CMP_W = OP_W + 1;

   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [NUM_OPS-1:0]   r_sel, w_sel_nxt;
   logic [OP_W-1:0]      r_op_q, w_op_q_nxt;

   logic [NUM_OPS-1:0]   w_onehot;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_multi;
   logic                 w_abort;
   logic                 w_illegal_q;

   decod_onehot #(
      .OP_W    (OP_W),
      .NUM_OPS (NUM_OPS)
   ) u_onehot (
      .i_op  (bus.op),
      .o_sel (w_onehot)
   );

   assign w_ready  = (r_state != ST_EXEC);
   assign w_accept = bus.op_valid && w_ready;
   // An out-of-range opcode decodes to zero, so it can never hit an MC_MASK bit.
   assign w_multi  = |(w_onehot & MC_MASK);

`ifdef DECOD_ABORT_EN
   assign w_abort  = abort && (r_state != ST_IDLE);
`else
   assign w_abort  = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_op_q_nxt  = r_op_q;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               w_op_q_nxt = bus.op;
               w_sel_nxt  = w_onehot;
               if (w_multi) begin
                  w_state_nxt = ST_EXEC;
                  w_cnt_nxt   = CNT_W'(MC_LAT - 1);
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end else if (r_state == ST_DONE) begin
               w_state_nxt = ST_IDLE;
               w_sel_nxt   = '0;
            end
         end
         ST_EXEC: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase

      // Abort outranks everything, including an accept in DONE.
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
         w_sel_nxt   = '0;
         w_cnt_nxt   = '0;
         w_op_q_nxt  = r_op_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_op_q  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
         r_op_q  <= w_op_q_nxt;
      end
   end

   assign w_illegal_q  = !op_legal(int'({1'b0, r_op_q}), NUM_OPS);

   assign bus.op_ready = w_ready;
   assign bus.sel      = r_sel;
   assign bus.op_q     = r_op_q;
   assign bus.busy     = (r_state == ST_EXEC);
   assign bus.done     = (r_state == ST_DONE);
   assign bus.illegal  = (r_state == ST_DONE) && w_illegal_q;

   // Structural invariants of the select register and handshake.
   a_sel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_sel));
   a_busy_ready  : assert property (@(posedge clk) disable iff (!rst_n) !(bus.busy && bus.op_ready));
   a_busy_done   : assert property (@(posedge clk) disable iff (!rst_n) !(bus.busy && bus.done));

   // Width of the comparison operand is kept explicit for NUM_OPS == 2**OP_W.
   logic [CMP_W-1:0] w_num_ops_unused;
   assign w_num_ops_unused = CMP_W'(NUM_OPS);

endmodule
